sig_mmio_uart: RTL and testbench
================================

# sig_mmio_uart

Synthesizable replacement for the simulation-only signature/halt handling on the core's data-memory write port. It sits directly downstream of the core's `dmem_wr_*` outputs, in parallel with the data memory. It decodes two MMIO addresses:

- **Signature port:** each word written there is queued and emitted on a UART TX line as 8 lowercase ASCII hex digits plus `\n`.
- **Halt port:** a magic write raises a sticky halt and suppresses the memory write.

The testbench or FPGA top uses `done` to end a run once all signature words are on the wire.

## Interface
Parameters:
- `SIG_ADDR`, 32'hF0000004: signature word address.
- `HALT_ADDR`, 32'hF0000000: halt address.
- `HALT_MAGIC`, 32'hCAFECAFE: data value that triggers halt.
- `FIFO_DEPTH`, 16: signature FIFO entries; power of two, ≥2.
- `CLKS_PER_BIT`, 868: sysclk cycles per UART bit; ≥2.

Ports:
- `sysclk`  in  1  clock, all logic on rising edge.
- `nrst_in`  in  1  reset, asynchronous, active-low.
- `dmem_wr_en`  in  1  core write strobe, one word per cycle while high.
- `dmem_wr_addr`  in  32  core write address.
- `dmem_wr_data`  in  32  core write data.
- `mem_wr_en`  out  1  gated write enable to data memory (combinational).
- `uart_tx`  out  1  serial output: 8N1, LSB first, idle high.
- `halted`  out  1  sticky; magic halt write seen.
- `done`  out  1  `halted` and FIFO empty and TX idle.
- `overflow`  out  1  sticky; a signature word was dropped.
- `sig_count`  out  16  signature words accepted (wraps at 65535→0).

## Operation
- **Decode:**
  - `sig_hit = dmem_wr_en && addr==SIG_ADDR`
  - `halt_hit = dmem_wr_en && addr==HALT_ADDR && data==HALT_MAGIC`
- **`mem_wr_en`:** `dmem_wr_en && !halt_hit`. Signature writes and non-magic writes to HALT_ADDR still reach memory.
- **Writes after halt:**
  - After `halted`=1, `sig_hit` is ignored: no push, no count, no overflow.
  - `mem_wr_en` is unaffected by `halted`.
- **FIFO push:**
  - On `sig_hit`, push if occupancy < FIFO_DEPTH or a pop occurs the same cycle.
  - Otherwise drop the word and set `overflow`.
  - `sig_count` increments only on an accepted push.
- **TX FSM states:** IDLE, START, DATA, STOP.
  - **IDLE:** if FIFO non-empty, pop into a 32-bit word register, set char index=0, go to START.
  - **START:** `uart_tx`=0 for CLKS_PER_BIT cycles.
  - **DATA:** 8 bits of the current char, LSB first, each CLKS_PER_BIT cycles.
  - **STOP:** `uart_tx`=1 for CLKS_PER_BIT cycles. Then, if char index<8, increment the index and go to START. If index==8, go to IDLE.
- **Char mapping:**
  - Index k=0..7 sends nibble `word[31-4k -: 4]`.
  - 0–9 map to 0x30–0x39; 10–15 map to 0x61–0x66.
  - Index 8 sends 0x0A.
- **Per-word frame:** 9 chars × 10 bits × CLKS_PER_BIT cycles.
- **Bit timer:** counter 0..CLKS_PER_BIT-1, cleared at every state entry.

## Timing
- **Reset values:** `uart_tx`=1, `halted`=0, `done`=0, `overflow`=0, `sig_count`=0, FSM=IDLE, FIFO empty.
- **Reset mid-frame:** `uart_tx` returns high immediately (asynchronous). The queued and in-flight words are discarded.
- **Write → line latency:**
  - Word pushed at edge of cycle N (write presented in cycle N).
  - IDLE pops at edge N+1.
  - `uart_tx` falls after edge N+1, i.e. low during cycle N+2.
- **Halt:** `halted` is high from the edge ending the halt write cycle.
- **`done`:** registered; rises one cycle after the condition (`halted`, FIFO empty, FSM in IDLE) first holds.
- **Back-to-back writes:** one per cycle is supported. Capacity before drop is FIFO_DEPTH+1 words, because the first word leaves for the word register at N+1.
- **Simultaneous events:**
  - Push into a full FIFO while IDLE pops the same cycle: accepted.
  - `sig_hit` and `halt_hit` cannot coincide because the addresses differ.
- **Pointers:** read/write pointers wrap modulo FIFO_DEPTH. Occupancy is kept in a $clog2(FIFO_DEPTH)+1-bit count.

## Test plan
(All scenarios use CLKS_PER_BIT=4, FIFO_DEPTH=16.)
- **Reset:** hold `nrst_in`=0 → all outputs at reset values; `uart_tx`=1 throughout.
- **Single word:** write 32'hDEADBEEF to F0000004 at cycle N →
  - `mem_wr_en`=1 in cycle N.
  - `uart_tx` low at N+2.
  - Decoded bytes are 64 65 61 64 62 65 65 66 0A.
  - Line idle again after 360 cycles; `sig_count`=1.
- **Overflow:** 18 consecutive cycles of signature writes, data 0..17 →
  - `overflow`=1 after the 18th; `sig_count`=17.
  - The line emits words 00000000..00000010; word 00000011 never appears.
- **Halt gating:**
  - Write 32'h12345678 to F0000000 → `mem_wr_en`=1, `halted`=0.
  - Write CAFECAFE to F0000000 → `mem_wr_en`=0 that cycle; `halted`=1 next cycle.
  - A subsequent signature write → `sig_count` unchanged.
- **Done ordering:** push 2 words, then halt immediately → `done` stays 0 until the second `\n` stop bit completes, then goes 1 one cycle after FSM reaches IDLE.
- **Reset mid-transmission:** pulse `nrst_in` low during DATA of word 1 with 3 words queued →
  - `uart_tx`=1 immediately; `sig_count`=0.
  - No further frames after release.

Source files
------------

// File: rtl/sig_mmio_uart.sv
// Signature/halt MMIO sink: signature words go out on UART as 8 hex digits + '\n'.
// Latency: word written in cycle N is popped at edge N+1, start bit on the line in cycle N+2.
// Backpressure: none toward the core; a word arriving at a full queue is dropped and flagged.

module sig_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             push_ok,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             full;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign push_ok = push && (!full || do_pop);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module sig_mmio_uart #(
  parameter logic [31:0] SIG_ADDR     = 32'hF000_0004,
  parameter logic [31:0] HALT_ADDR    = 32'hF000_0000,
  parameter logic [31:0] HALT_MAGIC   = 32'hCAFE_CAFE,
  parameter int          FIFO_DEPTH   = 16,
  parameter int          CLKS_PER_BIT = 868
) (
  input  logic        sysclk,
  input  logic        nrst_in,
  input  logic        dmem_wr_en,
  input  logic [31:0] dmem_wr_addr,
  input  logic [31:0] dmem_wr_data,
  output logic        mem_wr_en,
  output logic        uart_tx,
  output logic        halted,
  output logic        done,
  output logic        overflow,
  output logic [15:0] sig_count
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TICK_MAX = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  tx_state_t     state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    bit_idx, bit_n;
  logic [3:0]    char_idx, char_n;
  logic [31:0]   word, word_n;
  logic [7:0]    cur_char_n;
  logic          tx_n;
  logic          tick;
  logic          pop;
  logic          sig_hit, halt_hit, push_req, push_ok, fifo_empty;
  logic [31:0]   fifo_dat;

  assign sig_hit   = dmem_wr_en && (dmem_wr_addr == SIG_ADDR);
  assign halt_hit  = dmem_wr_en && (dmem_wr_addr == HALT_ADDR) && (dmem_wr_data == HALT_MAGIC);
  assign mem_wr_en = dmem_wr_en && !halt_hit;
  assign push_req  = sig_hit && !halted;
  assign tick      = (timer == TICK_MAX);

  sig_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (sysclk),
    .rst_n    (nrst_in),
    .push     (push_req),
    .push_dat (dmem_wr_data),
    .pop      (pop),
    .push_ok  (push_ok),
    .pop_dat  (fifo_dat),
    .empty    (fifo_empty)
  );

  // Index 8 is the trailing newline; 0..7 walk the word from the top nibble down.
  function automatic logic [7:0] hex_char(input logic [31:0] w, input logic [3:0] idx);
    logic [31:0] sh;
    logic [3:0]  nib;
    sh  = w << {idx[2:0], 2'b00};
    nib = sh[31:28];
    if (idx == 4'd8)       return 8'h0A;
    else if (nib < 4'd10)  return 8'h30 + {4'h0, nib};
    else                   return 8'h57 + {4'h0, nib};
  endfunction

  always_comb begin
    state_n = state;
    timer_n = timer + 1'b1;
    bit_n   = bit_idx;
    char_n  = char_idx;
    word_n  = word;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        timer_n = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          word_n  = fifo_dat;
          char_n  = '0;
          state_n = START;
        end
      end
      START: if (tick) begin
        timer_n = '0;
        bit_n   = '0;
        state_n = DATA;
      end
      DATA: if (tick) begin
        timer_n = '0;
        if (bit_idx == 3'd7) state_n = STOP;
        else                 bit_n   = bit_idx + 1'b1;
      end
      STOP: if (tick) begin
        timer_n = '0;
        if (char_idx == 4'd8) begin
          state_n = IDLE;
        end else begin
          char_n  = char_idx + 1'b1;
          state_n = START;
        end
      end
      default: state_n = IDLE;
    endcase
    // Line level is registered from the next state so the pin never glitches.
    cur_char_n = hex_char(word_n, char_n);
    tx_n = 1'b1;
    if (state_n == START)     tx_n = 1'b0;
    else if (state_n == DATA) tx_n = cur_char_n[bit_n];
  end

  always_ff @(posedge sysclk or negedge nrst_in) begin
    if (!nrst_in) begin
      state     <= IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      char_idx  <= '0;
      word      <= '0;
      uart_tx   <= 1'b1;
      halted    <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      sig_count <= '0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      bit_idx  <= bit_n;
      char_idx <= char_n;
      word     <= word_n;
      uart_tx  <= tx_n;
      if (halt_hit)              halted    <= 1'b1;
      if (push_req && !push_ok)  overflow  <= 1'b1;
      if (push_ok)               sig_count <= sig_count + 16'd1;
      done <= halted && fifo_empty && (state == IDLE);
    end
  end
endmodule

// File: tb/tb_sig_mmio_uart.sv
// Bench for sig_mmio_uart: UART receiver plus byte scoreboard, with timing and flag checks.
module tb_sig_mmio_uart;
  localparam logic [31:0] SIG  = 32'hF000_0004;
  localparam logic [31:0] HALT = 32'hF000_0000;
  localparam int CPB = 4;

  logic        sysclk;
  logic        nrst_in;
  logic        dmem_wr_en;
  logic [31:0] dmem_wr_addr;
  logic [31:0] dmem_wr_data;
  logic        mem_wr_en;
  logic        uart_tx;
  logic        halted;
  logic        done;
  logic        overflow;
  logic [15:0] sig_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sb[$];
  int   extra_cnt = 0;
  int   mon_cnt   = 0;
  logic mon_busy  = 1'b0;
  logic [7:0] mon_byte;

  sig_mmio_uart #(
    .SIG_ADDR     (SIG),
    .HALT_ADDR    (HALT),
    .HALT_MAGIC   (32'hCAFE_CAFE),
    .FIFO_DEPTH   (16),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .sysclk       (sysclk),
    .nrst_in      (nrst_in),
    .dmem_wr_en   (dmem_wr_en),
    .dmem_wr_addr (dmem_wr_addr),
    .dmem_wr_data (dmem_wr_data),
    .mem_wr_en    (mem_wr_en),
    .uart_tx      (uart_tx),
    .halted       (halted),
    .done         (done),
    .overflow     (overflow),
    .sig_count    (sig_count)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + 8'(n);
    return 8'h61 + 8'(n) - 8'd10;
  endfunction

  task automatic push_word(input logic [31:0] w);
    for (int k = 0; k < 8; k++) sb.push_back(hexc(4'(w >> (28 - 4 * k))));
    sb.push_back(8'h0A);
  endtask

  // Receiver sampling mid-bit; detection cycle is count 0 of the start bit.
  always @(negedge sysclk) begin
    if (!nrst_in) begin
      mon_busy = 1'b0;
    end else if (!mon_busy) begin
      if (uart_tx === 1'b0) begin
        mon_busy = 1'b1;
        mon_cnt  = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == 2) begin
        chk("start_bit", 32'(uart_tx), 32'd0);
      end else if (mon_cnt >= 6 && mon_cnt <= 34 && ((mon_cnt - 2) % CPB) == 0) begin
        mon_byte = {uart_tx, mon_byte[7:1]};
      end else if (mon_cnt == 38) begin
        chk("stop_bit", 32'(uart_tx), 32'd1);
        mon_busy = 1'b0;
        if (sb.size() == 0) extra_cnt++;
        else chk("rx_byte", 32'(mon_byte), 32'(sb.pop_front()));
      end
    end
  end

  task automatic do_wr(input logic [31:0] a, input logic [31:0] d, output logic we);
    dmem_wr_en   = 1'b1;
    dmem_wr_addr = a;
    dmem_wr_data = d;
    #1 we = mem_wr_en;
    @(posedge sysclk);
    #1 dmem_wr_en = 1'b0;
  endtask

  task automatic reset_dut();
    dmem_wr_en = 1'b0;
    nrst_in    = 1'b0;
    repeat (3) @(posedge sysclk);
    #1 nrst_in = 1'b1;
    sb.delete();
    extra_cnt = 0;
    @(posedge sysclk);
    #1;
  endtask

  task automatic idle_watch(input int n, output int lows);
    lows = 0;
    repeat (n) begin
      @(negedge sysclk);
      if (uart_tx !== 1'b1) lows++;
    end
  endtask

  initial begin
    logic we;
    int   bad;
    int   c;
    nrst_in = 1'b1;
    dmem_wr_en = 1'b0; dmem_wr_addr = '0; dmem_wr_data = '0;
    #2 nrst_in = 1'b0;

    // Reset held with a signature write pending: nothing may leave.
    dmem_wr_en = 1'b1; dmem_wr_addr = SIG; dmem_wr_data = 32'h1234_5678;
    bad = 0;
    repeat (5) begin
      @(negedge sysclk);
      if (uart_tx !== 1'b1) bad++;
    end
    chk("rst_tx_hold", 32'(bad), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_sig_count", 32'(sig_count), 32'd0);
    reset_dut();
    chk("rst_tx_after", 32'(uart_tx), 32'd1);

    // Single word
    push_word(32'hDEAD_BEEF);
    do_wr(SIG, 32'hDEAD_BEEF, we);
    chk("single_we", 32'(we), 32'd1);
    chk("tx_n1_high", 32'(uart_tx), 32'd1);
    @(posedge sysclk); #1;
    chk("tx_n2_low", 32'(uart_tx), 32'd0);
    repeat (360) @(posedge sysclk);
    #1;
    chk("single_idle", 32'(uart_tx), 32'd1);
    chk("single_drain", 32'(sb.size()), 32'd0);
    chk("single_count", 32'(sig_count), 32'd1);
    chk("single_done", 32'(done), 32'd0);
    chk("single_extra", 32'(extra_cnt), 32'd0);

    // Overflow: 18 back-to-back writes, capacity is depth+1
    reset_dut();
    for (int i = 0; i < 18; i++) begin
      dmem_wr_en = 1'b1; dmem_wr_addr = SIG; dmem_wr_data = 32'(i);
      if (i < 17) push_word(32'(i));
      @(posedge sysclk); #1;
      if (i == 16) chk("ovf_before", 32'(overflow), 32'd0);
    end
    dmem_wr_en = 1'b0;
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(sig_count), 32'd17);
    for (int k = 0; k < 8000 && sb.size() != 0; k++) @(posedge sysclk);
    repeat (400) @(posedge sysclk);
    #1;
    chk("ovf_drain", 32'(sb.size()), 32'd0);
    chk("ovf_extra", 32'(extra_cnt), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Halt gating
    reset_dut();
    do_wr(HALT, 32'h1234_5678, we);
    chk("halt_nonmagic_we", 32'(we), 32'd1);
    chk("halt_nonmagic_h", 32'(halted), 32'd0);
    do_wr(HALT, 32'hCAFE_CAFE, we);
    chk("halt_magic_we", 32'(we), 32'd0);
    chk("halt_magic_h", 32'(halted), 32'd1);
    chk("halt_done_lag", 32'(done), 32'd0);
    do_wr(SIG, 32'hAAAA_5555, we);
    chk("halt_sig_we", 32'(we), 32'd1);
    chk("halt_sig_count", 32'(sig_count), 32'd0);
    chk("halt_done", 32'(done), 32'd1);
    idle_watch(100, bad);
    chk("halt_no_tx", 32'(bad), 32'd0);

    // Done ordering: two words then halt
    reset_dut();
    push_word(32'h0123_4567);
    push_word(32'h89AB_CDEF);
    do_wr(SIG, 32'h0123_4567, we);
    do_wr(SIG, 32'h89AB_CDEF, we);
    do_wr(HALT, 32'hCAFE_CAFE, we);
    chk("done_halt_we", 32'(we), 32'd0);
    c = 0;
    while (!done && c < 2000) begin
      @(posedge sysclk); #1;
      c++;
      if (c == 720) chk("done_early", 32'(done), 32'd0);
    end
    chk("done_cycle", 32'(c), 32'd721);
    chk("done_val", 32'(done), 32'd1);
    chk("done_drained", 32'(sb.size()), 32'd0);
    chk("done_count", 32'(sig_count), 32'd2);

    // Reset in the middle of the first character
    reset_dut();
    do_wr(SIG, 32'h0000_0000, we);
    do_wr(SIG, 32'h1111_1111, we);
    do_wr(SIG, 32'h2222_2222, we);
    repeat (4) @(posedge sysclk);
    #1;
    chk("tx_pre_rst", 32'(uart_tx), 32'd0);
    nrst_in = 1'b0;
    #1;
    chk("tx_async_rst", 32'(uart_tx), 32'd1);
    chk("rst_mid_count", 32'(sig_count), 32'd0);
    repeat (3) @(posedge sysclk);
    #1 nrst_in = 1'b1;
    idle_watch(1000, bad);
    chk("rst_mid_quiet", 32'(bad), 32'd0);
    chk("rst_mid_extra", 32'(extra_cnt), 32'd0);
    chk("rst_mid_sb", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
